matrix_cmp_ctrl: RTL and testbench

Sequencing controller that walks the ROW×COLUMN reference matrix produced by `matrix_module` in row-major order. It compares each element against a stream of test-vector bytes delivered over a valid/ready handshake. It counts mismatches, captures the coordinates of the first mismatch, and reports a pass/fail verdict with a one-cycle done pulse. It sits between the test-vector source and `matrix_module`, and it is the only consumer of `output_mat`.

---
 rtl/matrix_pkg.sv | 22 ++
 rtl/matrix_idx_ctr.sv | 39 +++
 rtl/matrix_cmp_ctrl.sv | 127 ++++++++++++
 tb/tb_matrix_cmp_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared types and defaults for the matrix compare controller slice.
package matrix_pkg;

  localparam int ROW_DEFAULT    = 4;
  localparam int COLUMN_DEFAULT = 4;
  localparam int DATA_W_DEFAULT = 8;

  typedef logic [DATA_W_DEFAULT-1:0] elem_t;
  typedef elem_t [ROW_DEFAULT-1:0][COLUMN_DEFAULT-1:0] mat_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE_S
  } cmp_state_e;

  // Index width for a dimension of size n; a single-entry dimension still gets one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matrix_idx_ctr.sv
// Row/column walker for the reference matrix: row-major, column-fastest, with a last-element flag.
module matrix_idx_ctr
  import matrix_pkg::*;
#(
  parameter int ROW    = ROW_DEFAULT,
  parameter int COLUMN = COLUMN_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      en,
  output logic [idx_w(ROW)-1:0]     row,
  output logic [idx_w(COLUMN)-1:0]  col,
  output logic                      last
);

  localparam int RW = idx_w(ROW);
  localparam int CW = idx_w(COLUMN);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROW - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLUMN - 1);

  assign last = (row == ROW_LAST) && (col == COL_LAST);

  // Advance the column each enabled cycle and carry into the row; a one-entry dimension never leaves zero.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      row <= '0;
      col <= '0;
    end else if (en) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

endmodule

// File: rtl/matrix_cmp_ctrl.sv
// Compares a streamed test vector against the reference matrix and reports errors and a pass/fail verdict.
module matrix_cmp_ctrl
  import matrix_pkg::*;
#(
  parameter int ROW    = ROW_DEFAULT,
  parameter int COLUMN = COLUMN_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     start,
  input  logic [ROW-1:0][COLUMN-1:0][DATA_W-1:0]   mat_in,
  input  logic                                     vec_valid,
  input  logic [DATA_W-1:0]                        vec_data,
  output logic                                     vec_ready,
  output logic                                     busy,
  output logic                                     done,
  output logic                                     pass,
  output logic [$clog2(ROW*COLUMN+1)-1:0]          err_count,
  output logic                                     first_err_valid,
  output logic [idx_w(ROW)-1:0]                    first_err_row,
  output logic [idx_w(COLUMN)-1:0]                 first_err_col
);

  localparam int RW    = idx_w(ROW);
  localparam int CW    = idx_w(COLUMN);
  localparam int ERR_W = $clog2(ROW*COLUMN+1);
  localparam logic [ERR_W-1:0] ERR_MAX = ERR_W'(ROW*COLUMN);

  cmp_state_e state;
  cmp_state_e state_next;

  logic          start_run;
  logic          accept;
  logic          mismatch;
  logic          last;
  logic [RW-1:0] row;
  logic [CW-1:0] col;

  // Handshake is derived from the state register, never from vec_ready, so there is no combinational path from vec_valid.
  assign accept   = vec_valid && (state == RUN);
  assign mismatch = accept && (vec_data != mat_in[row][col]);

  matrix_idx_ctr #(
    .ROW    (ROW),
    .COLUMN (COLUMN)
  ) u_idx (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_run),
    .en   (accept),
    .row  (row),
    .col  (col),
    .last (last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and state-decoded outputs; start is only honoured outside RUN.
  always_comb begin
    state_next = state;
    start_run  = 1'b0;
    vec_ready  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          start_run  = 1'b1;
        end
      end
      RUN: begin
        vec_ready = 1'b1;
        busy      = 1'b1;
        if (accept && last) begin
          state_next = DONE_S;
        end
      end
      DONE_S: begin
        done = 1'b1;
        if (start) begin
          state_next = RUN;
          start_run  = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Error accumulation and verdict; results persist until the next run starts, and the final beat's mismatch counts toward pass.
  always_ff @(posedge clk) begin
    if (rst || start_run) begin
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_row   <= '0;
      first_err_col   <= '0;
      pass            <= 1'b0;
    end else if (accept) begin
      if (mismatch) begin
        if (err_count != ERR_MAX) begin
          err_count <= err_count + ERR_W'(1);
        end
        if (!first_err_valid) begin
          first_err_valid <= 1'b1;
          first_err_row   <= row;
          first_err_col   <= col;
        end
      end
      if (last) begin
        pass <= (err_count == '0) && !mismatch;
      end
    end
  end

endmodule

// File: tb/tb_matrix_cmp_ctrl.sv
// Directed self-checking bench for matrix_cmp_ctrl with hand-computed expectations.
module tb_matrix_cmp_ctrl;

  localparam int ROW    = 4;
  localparam int COLUMN = 4;
  localparam int DATA_W = 8;

  logic                                   clk = 1'b0;
  logic                                   rst;
  logic                                   start;
  logic [ROW-1:0][COLUMN-1:0][DATA_W-1:0] mat_in;
  logic                                   vec_valid;
  logic [DATA_W-1:0]                      vec_data;
  logic                                   vec_ready;
  logic                                   busy;
  logic                                   done;
  logic                                   pass;
  logic [4:0]                             err_count;
  logic                                   first_err_valid;
  logic [1:0]                             first_err_row;
  logic [1:0]                             first_err_col;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] ref_mat [16] = '{8'h00, 8'h00, 8'h01, 8'h01,
                               8'h01, 8'h02, 8'h03, 8'h01,
                               8'h02, 8'h01, 8'h02, 8'h01,
                               8'h01, 8'h02, 8'h03, 8'h01};
  logic [7:0] stream [16];

  matrix_cmp_ctrl #(
    .ROW    (ROW),
    .COLUMN (COLUMN),
    .DATA_W (DATA_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .mat_in          (mat_in),
    .vec_valid       (vec_valid),
    .vec_data        (vec_data),
    .vec_ready       (vec_ready),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .err_count       (err_count),
    .first_err_valid (first_err_valid),
    .first_err_row   (first_err_row),
    .first_err_col   (first_err_col)
  );

  // 10-time-unit clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic idleCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ready"}, vec_ready, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_pass"}, pass, 0);
    checkOutput({tag, "_errcnt"}, err_count, 0);
    checkOutput({tag, "_fev"}, first_err_valid, 0);
    checkOutput({tag, "_frow"}, first_err_row, 0);
    checkOutput({tag, "_fcol"}, first_err_col, 0);
  endtask

  // Starts a run from the current post-edge slot and streams 'stream'; returns in the DONE_S cycle
  // (or the cycle after reset when abort_at >= 0).
  task automatic applyStimulus(input bit gapped, input bit mid_start, input int abort_at);
    int  beats;
    int  cyc;
    bit  acc;
    bit  aborted;
    beats   = 0;
    cyc     = 0;
    aborted = 0;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("start_busy", busy, 1);
    checkOutput("start_ready", vec_ready, 1);
    checkOutput("start_errcnt_clr", err_count, 0);
    checkOutput("start_fev_clr", first_err_valid, 0);
    checkOutput("start_pass_clr", pass, 0);
    while (beats < 16 && cyc < 100) begin
      if (abort_at >= 0 && beats == abort_at) begin
        vec_valid = 1'b0;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkResetValues("abort");
        aborted = 1;
        break;
      end
      vec_valid = gapped ? ((cyc % 2) == 0) : 1'b1;
      vec_data  = stream[beats];
      start     = (mid_start && cyc == 5) ? 1'b1 : 1'b0;
      acc       = vec_valid && vec_ready;
      @(posedge clk);
      #1;
      cyc++;
      start = 1'b0;
      if (acc) beats++;
      if (beats < 16) checkOutput("no_early_done", done, 0);
    end
    vec_valid = 1'b0;
    start     = 1'b0;
    if (!aborted) begin
      checkOutput("run_beats", beats, 16);
      checkOutput("run_cycles", cyc, gapped ? 31 : 16);
      checkOutput("end_done", done, 1);
      checkOutput("end_busy", busy, 0);
      checkOutput("end_ready", vec_ready, 0);
    end
  endtask

  initial begin
    for (int r = 0; r < ROW; r++)
      for (int c = 0; c < COLUMN; c++)
        mat_in[r][c] = ref_mat[r*COLUMN + c];
    rst       = 1'b1;
    start     = 1'b0;
    vec_valid = 1'b0;
    vec_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkResetValues("reset");

    // Bytes offered while idle must be ignored.
    vec_valid = 1'b1;
    vec_data  = 8'hAA;
    repeat (3) idleCycle();
    checkOutput("idle_ready", vec_ready, 0);
    checkOutput("idle_errcnt", err_count, 0);
    checkOutput("idle_busy", busy, 0);
    vec_valid = 1'b0;

    // Fully matching run.
    stream = ref_mat;
    applyStimulus(0, 0, -1);
    checkOutput("t1_pass", pass, 1);
    checkOutput("t1_errcnt", err_count, 0);
    checkOutput("t1_fev", first_err_valid, 0);
    idleCycle();
    checkOutput("t1_done_pulse", done, 0);
    checkOutput("t1_pass_hold", pass, 1);
    checkOutput("t1_idle_busy", busy, 0);

    // Two mismatches: [1][2] and [3][0].
    stream     = ref_mat;
    stream[6]  = 8'h07;
    stream[12] = 8'hFF;
    applyStimulus(0, 0, -1);
    checkOutput("t2_errcnt", err_count, 2);
    checkOutput("t2_fev", first_err_valid, 1);
    checkOutput("t2_frow", first_err_row, 1);
    checkOutput("t2_fcol", first_err_col, 2);
    checkOutput("t2_pass", pass, 0);
    repeat (2) idleCycle();
    checkOutput("t2_errcnt_hold", err_count, 2);
    checkOutput("t2_frow_hold", first_err_row, 1);

    // Mismatch only on the last element.
    stream     = ref_mat;
    stream[15] = 8'h00;
    applyStimulus(0, 0, -1);
    checkOutput("t3_pass", pass, 0);
    checkOutput("t3_errcnt", err_count, 1);
    checkOutput("t3_frow", first_err_row, 3);
    checkOutput("t3_fcol", first_err_col, 3);
    idleCycle();

    // Gapped valid with a stray start mid-run.
    stream = ref_mat;
    applyStimulus(1, 1, -1);
    checkOutput("t4_pass", pass, 1);
    checkOutput("t4_errcnt", err_count, 0);
    idleCycle();

    // Reset after 7 beats (one mismatch already counted), then a clean run.
    stream     = ref_mat;
    stream[6]  = 8'h07;
    applyStimulus(0, 0, 7);
    idleCycle();
    checkOutput("t5_no_done", done, 0);
    stream = ref_mat;
    applyStimulus(0, 0, -1);
    checkOutput("t5_pass", pass, 1);
    checkOutput("t5_errcnt", err_count, 0);
    idleCycle();

    // Back-to-back: failing run, then start during DONE_S for a clean run.
    stream     = ref_mat;
    stream[6]  = 8'h07;
    stream[12] = 8'hFF;
    applyStimulus(0, 0, -1);
    checkOutput("t6a_errcnt", err_count, 2);
    stream = ref_mat;
    applyStimulus(0, 0, -1);
    checkOutput("t6b_pass", pass, 1);
    checkOutput("t6b_errcnt", err_count, 0);
    checkOutput("t6b_fev", first_err_valid, 0);
    idleCycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
